// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Op codes follow funct3; helpers decode operand signedness and result selection.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_high(input logic [2:0] op);
        return ~op[2] & (op[1:0] != 2'b00);
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_cneg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module mdu_cneg #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] y
);

    assign y = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: one shift-add / restoring shift-subtract step per cycle.
// Optional feature: define MDU_EARLY_OUT_EN to finish trivial cases in the accept cycle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg;
    logic [2:0]          op_reg;
    logic [XLEN-1:0]     ma_reg;
    logic [2*XLEN-1:0]   acc_reg;
    logic                neg_reg;
    logic                div_zero_reg;
    logic [XLEN-1:0]     result_reg;

    logic                accept;
    logic                a_neg, b_neg, b_zero, sign_next;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                early;
    logic [XLEN-1:0]     early_result;

    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign a_neg  = a[XLEN-1] & a_signed(op);
    assign b_neg  = b[XLEN-1] & b_signed(op);
    assign b_zero = (b == '0);
    // Remainder takes the dividend's sign; quotient and product take the XOR.
    assign sign_next = is_rem(op) ? a_neg : (a_neg ^ b_neg);

    mdu_cneg #(.W(XLEN)) u_mag_a (.value(a), .negate(a_neg), .y(mag_a));
    mdu_cneg #(.W(XLEN)) u_mag_b (.value(b), .negate(b_neg), .y(mag_b));

`ifdef MDU_EARLY_OUT_EN
    logic ovf;
    assign ovf = ((op == OP_DIV) || (op == OP_REM))
                 && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    always_comb begin
        early        = 1'b0;
        early_result = '0;
        if (is_div(op)) begin
            early = b_zero | ovf;
            if (b_zero)
                early_result = is_rem(op) ? a : '1;
            else
                early_result = is_rem(op) ? '0 : a;
        end else begin
            early = (a == '0) | b_zero;
        end
    end
`else
    assign early        = 1'b0;
    assign early_result = '0;
`endif

    // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (acc_reg[0] ? ma_reg : {XLEN{1'b0}})};
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_step;
    assign div_trial = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]} - {1'b0, ma_reg};
    assign div_step  = div_trial[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] fix_raw, fix_neg;
    logic [XLEN-1:0]   fix_result;
    always_comb begin
        fix_raw = acc_reg;
        if (is_div(op_reg))
            fix_raw = is_rem(op_reg) ? {{XLEN{1'b0}}, acc_reg[2*XLEN-1:XLEN]}
                                     : {{XLEN{1'b0}}, acc_reg[XLEN-1:0]};
    end

    mdu_cneg #(.W(2*XLEN)) u_fix (.value(fix_raw), .negate(neg_reg), .y(fix_neg));

    always_comb begin
        fix_result = fix_neg[XLEN-1:0];
        if (!is_div(op_reg) && is_high(op_reg))
            fix_result = fix_neg[2*XLEN-1:XLEN];
        else if (is_div(op_reg) && !is_rem(op_reg) && div_zero_reg)
            fix_result = '1;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = early ? DONE : CALC;
            CALC:    if (cnt_reg == CNT_LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = start ? (early ? DONE : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_reg       <= '0;
            ma_reg       <= '0;
            acc_reg      <= '0;
            neg_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg       <= op;
                neg_reg      <= sign_next;
                div_zero_reg <= b_zero;
                cnt_reg      <= '0;
                if (is_div(op)) begin
                    ma_reg  <= mag_b;
                    acc_reg <= {{XLEN{1'b0}}, mag_a};
                end else begin
                    ma_reg  <= mag_a;
                    acc_reg <= {{XLEN{1'b0}}, mag_b};
                end
                if (early)
                    result_reg <= early_result;
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_reg + 1'b1;
                acc_reg <= is_div(op_reg) ? div_step : mul_step;
            end else if (state_reg == FIX) begin
                result_reg <= fix_result;
            end
        end
    end

    assign busy   = (state_reg == CALC) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN=32); honours MDU_EARLY_OUT_EN for special-case latency.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;
`ifdef MDU_EARLY_OUT_EN
    localparam int SP_LAT = 0;
`else
    localparam int SP_LAT = LAT;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request for one edge; returns 1 time unit after the sampling edge.
    task automatic do_start(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat counts edges after the sampling point until done is seen; busy_cyc counts busy samples.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp, input int exp_lat);
        int lat, bc;
        logic [XLEN-1:0] held;
        do_start(o, x, y);
        wait_done(lat, bc);
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(bc), 64'(exp_lat));
        check({tag, " busy&done"}, 64'(busy & done), 64'd0);
        held = result;
        @(posedge clk); #1;
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " result held"}, 64'(result), 64'(exp));
        $display("txn %s op=%0d a=%h b=%h result=%h latency=%0d", tag, o, x, y, held, lat);
    endtask

    initial begin
        int lat, bc;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op("MUL",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
        run_op("MULH",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT);
        run_op("MULHU",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        run_op("MULHSU",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT);
        run_op("DIV",     OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT);
        run_op("REM",     OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT);
        run_op("DIVU",    OP_DIVU,   32'd100,        32'd7,         32'd14,        LAT);
        run_op("REMU",    OP_REMU,   32'd100,        32'd7,         32'd2,         LAT);
        run_op("DIV0",    OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, SP_LAT);
        run_op("REM0",    OP_REM,    32'd5,          32'd0,         32'd5,         SP_LAT);
        run_op("DIVOVF",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
        run_op("REMOVF",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SP_LAT);
        run_op("MULZERO", OP_MUL,    32'd0,          32'd9,         32'd0,         SP_LAT);

        // start raised 5 edges into an op must be ignored
        do_start(OP_DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        op = OP_MUL; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("ignore latency", 64'(lat), 64'(LAT - 5));
        check("ignore result", 64'(result), 64'd14);
        $display("txn IGNORE result=%h latency_after_start=%0d", result, lat + 5);
        @(posedge clk); #1;

        // reset 10 edges into an op aborts it with no done
        do_start(OP_MUL, 32'd7, 32'd9);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1; #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        check("abort no done", 64'(done), 64'd0);
        $display("txn ABORT busy=%0d done=%0d result=%h", busy, done, result);
        run_op("MUL3x4", OP_MUL, 32'd3, 32'd4, 32'd12, LAT);

        // back-to-back: new start held in the DONE cycle
        do_start(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, bc);
        check("b2b first result", 64'(result), 64'd14);
        do_start(OP_DIVU, 32'd9, 32'd3);
        wait_done(lat, bc);
        check("b2b interval", 64'(lat + 1), 64'(LAT + 1));
        check("b2b second result", 64'(result), 64'd3);
        $display("txn B2B result=%h interval=%0d", result, lat + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
